data_mem_writer: RTL and testbench
==================================

DATA_MEM_WRITER -- requirements
Module: data_mem_writer

Interface
REQ-001 Parameter N_WORDS, default 64: number of 32-bit words written per load, legal range 1..256.
REQ-002 Parameter BASE_ADDR, default 8'h00: first data-memory word address written.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  pulse; begins a load when in IDLE or DONE.
REQ-006 byte_in  input  8  incoming data byte.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_ready  output  1  block accepts a byte this cycle.
REQ-009 we  output  1  data-memory write enable, one-cycle pulse per word.
REQ-010 waddr  output  8  data-memory word address, same address space the display decoder reads.
REQ-011 wdata  output  32  assembled word.
REQ-012 busy  output  1  high in COLLECT or WRITE.
REQ-013 done  output  1  high in DONE.
REQ-014 checksum  output  8  running byte sum (see Configuration).

Function
REQ-015 FSM states IDLE, COLLECT, WRITE, DONE; a byte is accepted when byte_valid && byte_ready at a rising edge.
REQ-016 IDLE: byte_ready=0, we=0; start=1 -> COLLECT, word counter=0, byte counter=0, waddr=BASE_ADDR.
REQ-017 COLLECT: byte_ready=1; accepted bytes pack little-endian: byte 0 -> wdata[7:0], byte 3 -> wdata[31:24].
REQ-018 COLLECT: on acceptance of byte 3 -> WRITE next cycle; byte_valid=0 leaves state, counters and partial word unchanged.
REQ-019 WRITE: we=1 for exactly one cycle with stable waddr/wdata, byte_ready=0; bytes offered are not accepted.
REQ-020 WRITE exit: if word counter==N_WORDS-1 -> DONE; else -> COLLECT, word counter+1, waddr+1.
REQ-021 waddr increments modulo 256; BASE_ADDR+N_WORDS>256 wraps to 8'h00 with no error.
REQ-022 Latency: 4th accepted byte at edge k -> we=1 during cycle k+1; minimum 5 cycles per word.
REQ-023 DONE: done=1, byte_ready=0, wdata and waddr hold last written values; start=1 -> COLLECT, restarting per REQ-016.
REQ-024 start asserted in COLLECT or WRITE is ignored.
REQ-025 Simultaneous start and byte_valid in IDLE/DONE: byte not accepted (byte_ready=0 that cycle).
REQ-026 we never asserts outside WRITE.

Reset
REQ-027 reset=1 at an edge -> IDLE; byte_ready=0, we=0, busy=0, done=0, waddr=BASE_ADDR, wdata=0, checksum=0, counters=0.
REQ-028 Reset mid-load (any state) discards partial word; no write pulse issued in the reset cycle or after.
REQ-029 reset has priority over start and byte_valid.

Configuration
REQ-030 Macro DATA_MEM_WRITER_CHECKSUM_EN defined: checksum = 8-bit modulo-256 sum of all bytes accepted since last start, cleared on start, held in DONE.
REQ-031 Macro undefined: checksum tied to 8'h00, no accumulator logic present; all other behaviour identical.

Structure
REQ-032 Package data_mem_writer_pkg holds the state enum, BYTES_PER_WORD=4 and ADDR_W=8 constants.
REQ-033 One sub-module, byte_packer: 2-bit byte index and 32-bit packing register with load/clear inputs.

Verification
REQ-034 N_WORDS=1, BASE_ADDR=0: start, bytes 11,22,33,44 back-to-back -> one we pulse, waddr=00, wdata=32'h44332211, done=1 next cycle.
REQ-035 N_WORDS=2: bytes with byte_valid gaps of 3 cycles -> two we pulses, waddr 00 then 01, byte_ready=0 in WRITE cycles.
REQ-036 BASE_ADDR=8'hFE, N_WORDS=3 -> writes at FE, FF, 00.
REQ-037 reset asserted after 2 bytes of word 0 -> no we pulse, all outputs at REQ-027 values; new start reloads from BASE_ADDR.
REQ-038 start pulsed during COLLECT -> no effect; start in DONE -> second load restarts at BASE_ADDR.
REQ-039 With DATA_MEM_WRITER_CHECKSUM_EN, bytes 80,80,01,02 -> checksum=8'h03; without macro -> checksum=8'h00.

Source files
------------

// File: rtl/data_mem_writer_pkg.sv
// Shared types and constants for the byte-stream to data-memory loader.
// Holds the FSM state encoding and the word/address geometry.
package data_mem_writer_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int ADDR_W         = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_DONE
   } state_t;

endpackage

// File: rtl/data_mem_writer_byte_packer.sv
// Little-endian byte packer: byte idx 0 lands in word[7:0].
// Ports: clk, reset, clear (restart), load (byte accepted), byte_in -> idx, word.
module byte_packer
   import data_mem_writer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        load,
   input  logic [7:0]  byte_in,
   output logic [1:0]  idx,
   output logic [31:0] word
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         idx  <= 2'd0;
         word <= 32'd0;
      end else if (load) begin
         word[{idx, 3'b000} +: 8] <= byte_in;
         // Wraps to 0 after the top byte, ready for the next word.
         idx <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/data_mem_writer.sv
// Collects a byte stream into 32-bit words and writes N_WORDS of them to
// data memory from BASE_ADDR up (address wraps mod 256).
// Ports: clk, reset (sync, active-high), start, byte_in/byte_valid/byte_ready
// stream in; we/waddr/wdata memory write; busy, done, checksum status.
// Optional feature: define DATA_MEM_WRITER_CHECKSUM_EN for a running byte sum;
// otherwise checksum is tied to zero.
module data_mem_writer
   import data_mem_writer_pkg::*;
#(
   parameter int          N_WORDS   = 64,
   parameter logic [7:0]  BASE_ADDR = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        we,
   output logic [7:0]  waddr,
   output logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [7:0]  checksum
);

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);
   localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   state_t            state;
   logic [ADDR_W-1:0] wcnt;
   logic [1:0]        idx;
   logic              accept;
   logic              restart;

   assign accept  = byte_valid && (state == S_COLLECT);
   assign restart = start && ((state == S_IDLE) || (state == S_DONE));

   byte_packer u_packer (
      .clk     (clk),
      .reset   (reset),
      .clear   (restart),
      .load    (accept),
      .byte_in (byte_in),
      .idx     (idx),
      .word    (wdata)
   );

   // Outputs are registered: each branch sets them for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         byte_ready <= 1'b0;
         we         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         waddr      <= BASE_ADDR;
         wcnt       <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state      <= S_COLLECT;
                  byte_ready <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  waddr      <= BASE_ADDR;
                  wcnt       <= '0;
               end
            end
            S_COLLECT: begin
               if (accept && (idx == LAST_BYTE)) begin
                  state      <= S_WRITE;
                  byte_ready <= 1'b0;
                  we         <= 1'b1;
               end
            end
            S_WRITE: begin
               we <= 1'b0;
               if (wcnt == LAST_WORD) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state      <= S_COLLECT;
                  byte_ready <= 1'b1;
                  wcnt       <= wcnt + 1'b1;
                  waddr      <= waddr + 1'b1;
               end
            end
            default: begin
               state      <= S_IDLE;
               byte_ready <= 1'b0;
               we         <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

`ifdef DATA_MEM_WRITER_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         csum <= 8'h00;
      end else if (accept) begin
         csum <= csum + byte_in;
      end
   end

   assign checksum = csum;
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_data_mem_writer.sv
// Directed bench for data_mem_writer: cycle table on a 1-word instance,
// plus gapped multi-word, address-wrap, restart and mid-load reset sequences.
module tb_data_mem_writer;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] byte_in;
   logic       byte_valid;

   logic        a_rdy, a_we, a_busy, a_done;
   logic [7:0]  a_wa, a_cs;
   logic [31:0] a_wd;
   logic        b_rdy, b_we, b_busy, b_done;
   logic [7:0]  b_wa, b_cs;
   logic [31:0] b_wd;
   logic        c_rdy, c_we, c_busy, c_done;
   logic [7:0]  c_wa, c_cs;
   logic [31:0] c_wd;

   int n_vec = 0;
   int n_bad = 0;
   logic rec = 1'b0;

   logic [39:0] qa[$];
   logic [39:0] qb[$];
   logic [39:0] qc[$];

   data_mem_writer #(.N_WORDS(1), .BASE_ADDR(8'h00)) dut_a (
      .clk(clk), .reset(reset), .start(start),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(a_rdy),
      .we(a_we), .waddr(a_wa), .wdata(a_wd),
      .busy(a_busy), .done(a_done), .checksum(a_cs)
   );

   data_mem_writer #(.N_WORDS(2), .BASE_ADDR(8'h00)) dut_b (
      .clk(clk), .reset(reset), .start(start),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(b_rdy),
      .we(b_we), .waddr(b_wa), .wdata(b_wd),
      .busy(b_busy), .done(b_done), .checksum(b_cs)
   );

   data_mem_writer #(.N_WORDS(3), .BASE_ADDR(8'hFE)) dut_c (
      .clk(clk), .reset(reset), .start(start),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(c_rdy),
      .we(c_we), .waddr(c_wa), .wdata(c_wd),
      .busy(c_busy), .done(c_done), .checksum(c_cs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ecs(input logic [7:0] x);
`ifdef DATA_MEM_WRITER_CHECKSUM_EN
      return x;
`else
      return 8'h00;
`endif
   endfunction

   task automatic chk(input string nm, input logic [39:0] act,
                      input logic [39:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic v,
                      input logic [7:0] b);
      reset      = r;
      start      = s;
      byte_valid = v;
      byte_in    = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_gap(input logic [7:0] b);
      cyc(1'b0, 1'b0, 1'b1, b);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   always @(negedge clk) begin
      if (rec) begin
         if (a_we) qa.push_back({a_wa, a_wd});
         if (b_we) begin
            qb.push_back({b_wa, b_wd});
            chk("b_ready_in_write", {39'd0, b_rdy}, 40'd0);
         end
         if (c_we) begin
            qc.push_back({c_wa, c_wd});
            chk("c_ready_in_write", {39'd0, c_rdy}, 40'd0);
         end
      end
   end

   typedef struct {
      logic        r, s, v;
      logic [7:0]  b;
      logic        rdy, we;
      logic [7:0]  wa;
      logic [31:0] wd;
      logic        bsy, dn;
      logic [7:0]  cs;
   } vec_t;

   vec_t tv[19];

   logic [39:0] ea[2];
   logic [39:0] eb[3];
   logic [39:0] ec[4];

   initial begin
      tv[0]  = '{1,0,0,8'h00, 0,0,8'h00,32'h00000000, 0,0,8'h00};
      tv[1]  = '{0,1,1,8'h99, 1,0,8'h00,32'h00000000, 1,0,8'h00};
      tv[2]  = '{0,0,1,8'h11, 1,0,8'h00,32'h00000011, 1,0,8'h11};
      tv[3]  = '{0,0,1,8'h22, 1,0,8'h00,32'h00002211, 1,0,8'h33};
      tv[4]  = '{0,0,0,8'h55, 1,0,8'h00,32'h00002211, 1,0,8'h33};
      tv[5]  = '{0,1,1,8'h33, 1,0,8'h00,32'h00332211, 1,0,8'h66};
      tv[6]  = '{0,0,1,8'h44, 0,1,8'h00,32'h44332211, 1,0,8'hAA};
      tv[7]  = '{0,0,1,8'h77, 0,0,8'h00,32'h44332211, 0,1,8'hAA};
      tv[8]  = '{0,0,0,8'h00, 0,0,8'h00,32'h44332211, 0,1,8'hAA};
      tv[9]  = '{0,1,0,8'h00, 1,0,8'h00,32'h00000000, 1,0,8'h00};
      tv[10] = '{0,0,1,8'h80, 1,0,8'h00,32'h00000080, 1,0,8'h80};
      tv[11] = '{0,0,1,8'h80, 1,0,8'h00,32'h00008080, 1,0,8'h00};
      tv[12] = '{1,1,1,8'h01, 0,0,8'h00,32'h00000000, 0,0,8'h00};
      tv[13] = '{0,1,0,8'h00, 1,0,8'h00,32'h00000000, 1,0,8'h00};
      tv[14] = '{0,0,1,8'h80, 1,0,8'h00,32'h00000080, 1,0,8'h80};
      tv[15] = '{0,0,1,8'h80, 1,0,8'h00,32'h00008080, 1,0,8'h00};
      tv[16] = '{0,0,1,8'h01, 1,0,8'h00,32'h00018080, 1,0,8'h01};
      tv[17] = '{0,0,1,8'h02, 0,1,8'h00,32'h02018080, 1,0,8'h03};
      tv[18] = '{0,0,0,8'h00, 0,0,8'h00,32'h02018080, 0,1,8'h03};

      ea[0] = {8'h00, 32'h13121110};
      ea[1] = {8'h00, 32'hC4C3C2C1};
      eb[0] = {8'h00, 32'h13121110};
      eb[1] = {8'h01, 32'h17161514};
      eb[2] = {8'h00, 32'hC4C3C2C1};
      ec[0] = {8'hFE, 32'h13121110};
      ec[1] = {8'hFF, 32'h17161514};
      ec[2] = {8'h00, 32'h1B1A1918};
      ec[3] = {8'hFE, 32'hC4C3C2C1};

      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;

      for (int i = 0; i < 19; i++) begin
         cyc(tv[i].r, tv[i].s, tv[i].v, tv[i].b);
         chk($sformatf("v%0d_ready", i), {39'd0, a_rdy}, {39'd0, tv[i].rdy});
         chk($sformatf("v%0d_we", i), {39'd0, a_we}, {39'd0, tv[i].we});
         chk($sformatf("v%0d_waddr", i), {32'd0, a_wa}, {32'd0, tv[i].wa});
         chk($sformatf("v%0d_wdata", i), {8'd0, a_wd}, {8'd0, tv[i].wd});
         chk($sformatf("v%0d_busy", i), {39'd0, a_busy}, {39'd0, tv[i].bsy});
         chk($sformatf("v%0d_done", i), {39'd0, a_done}, {39'd0, tv[i].dn});
         chk($sformatf("v%0d_cksum", i), {32'd0, a_cs},
             {32'd0, ecs(tv[i].cs)});
      end

      // Gapped bytes over three words on all instances.
      rec = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("c_start_waddr", {32'd0, c_wa}, {32'd0, 8'hFE});
      for (int i = 0; i < 12; i++) send_gap(8'(8'h10 + i));
      chk("b_done", {39'd0, b_done}, 40'd1);
      chk("b_waddr_hold", {32'd0, b_wa}, {32'd0, 8'h01});
      chk("b_wdata_hold", {8'd0, b_wd}, {8'd0, 32'h17161514});
      chk("c_done", {39'd0, c_done}, 40'd1);
      chk("c_waddr_hold", {32'd0, c_wa}, {32'd0, 8'h00});
      chk("c_cksum_hold", {32'd0, c_cs}, {32'd0, ecs(8'h02)});

      // Restart from DONE, then reset after two bytes.
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("c_restart_waddr", {32'd0, c_wa}, {32'd0, 8'hFE});
      chk("c_restart_busy", {38'd0, c_busy, c_done}, {38'd0, 2'b10});
      cyc(1'b0, 1'b0, 1'b1, 8'hAA);
      cyc(1'b0, 1'b0, 1'b1, 8'hBB);
      cyc(1'b1, 1'b0, 1'b1, 8'hCC);
      chk("c_rst_flags", {36'd0, c_rdy, c_we, c_busy, c_done}, 40'd0);
      chk("c_rst_waddr", {32'd0, c_wa}, {32'd0, 8'hFE});
      chk("c_rst_wdata", {8'd0, c_wd}, 40'd0);
      chk("c_rst_cksum", {32'd0, c_cs}, 40'd0);

      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'hC1);
      cyc(1'b0, 1'b0, 1'b1, 8'hC2);
      cyc(1'b0, 1'b0, 1'b1, 8'hC3);
      cyc(1'b0, 1'b0, 1'b1, 8'hC4);
      chk("c_we_latency", {39'd0, c_we}, 40'd1);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      rec = 1'b0;

      chk("a_writes", 40'(qa.size()), 40'd2);
      for (int i = 0; i < 2 && i < qa.size(); i++)
         chk($sformatf("a_wr%0d", i), qa[i], ea[i]);
      chk("b_writes", 40'(qb.size()), 40'd3);
      for (int i = 0; i < 3 && i < qb.size(); i++)
         chk($sformatf("b_wr%0d", i), qb[i], eb[i]);
      chk("c_writes", 40'(qc.size()), 40'd4);
      for (int i = 0; i < 4 && i < qc.size(); i++)
         chk($sformatf("c_wr%0d", i), qc[i], ec[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
